// File: rtl/mips_div_pkg.sv
// Shared types and constants for the sequential MIPS divider.
// Holds the divider state encoding, the default operand width and
// the iteration-counter width helper.
package mips_div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Default operand / result width (MIPS GPR width)
    localparam int DIV_WIDTH_DEFAULT = 32;

    // Counter width needed to count WIDTH iterations (never below 1 bit)
    function automatic int div_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Iteration counter width for the default operand width
    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration (purely combinational).
// Shifts {remainder, dividend} left by one, trial-subtracts the divisor
// in WIDTH+1-bit arithmetic and either keeps the difference (quotient
// bit 1) or restores the shifted remainder (quotient bit 0). The
// quotient bit is shifted into the freed LSB of the dividend register.
module seq_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_dsr,
    output logic [WIDTH-1:0] o_rem_next,
    output logic [WIDTH-1:0] o_dvd_next,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_q_bit;

    // The shifted remainder can need WIDTH+1 bits; because it is always
    // below twice the divisor, the difference fits in WIDTH+1 bits and
    // its MSB is a reliable sign.
    always_comb begin
        w_shifted  = {i_rem, i_dvd[WIDTH-1]};
        w_diff     = w_shifted - {1'b0, i_dsr};
        w_q_bit    = ~w_diff[WIDTH];
        o_q_bit    = w_q_bit;
        o_rem_next = w_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
        o_dvd_next = {i_dvd[WIDTH-2:0], w_q_bit};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV / DIVU in the MIPS execute stage.
// One quotient bit per cycle; latency WIDTH+1 edges from accepted start.
// Optional macro SEQ_DIVIDER_ZERO_FAST_EN: a zero divisor skips the
// iteration phase and completes one edge after start.
module seq_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock__i,
    input  logic             reset__i,
    input  logic             start__i,
    input  logic             signed__i,
    input  logic [WIDTH-1:0] dividend__i,
    input  logic [WIDTH-1:0] divisor__i,
    output logic             busy__o,
    output logic             done__o,
    output logic [WIDTH-1:0] quotient__o,
    output logic [WIDTH-1:0] remainder__o,
    output logic             divByZero__o
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;        // partial remainder
    logic [WIDTH-1:0] r_dvd;        // |dividend|, shifts into quotient
    logic [WIDTH-1:0] r_dsr;        // |divisor|
    logic [WIDTH-1:0] r_dvd_orig;   // untouched dividend for the /0 result
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_div_zero;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dsr_abs;
    logic             w_dsr_zero;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;
    logic             w_q_bit;

    // Operand conditioning at start: signs only matter for DIV. The most
    // negative value negates to itself, which is its correct unsigned
    // magnitude.
    always_comb begin
        w_dvd_neg  = signed__i & dividend__i[WIDTH-1];
        w_dsr_neg  = signed__i & divisor__i[WIDTH-1];
        w_dvd_abs  = w_dvd_neg ? -dividend__i : dividend__i;
        w_dsr_abs  = w_dsr_neg ? -divisor__i : divisor__i;
        w_dsr_zero = (divisor__i == '0);
    end

    seq_divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem      (r_rem),
        .i_dvd      (r_dvd),
        .i_dsr      (r_dsr),
        .o_rem_next (w_rem_next),
        .o_dvd_next (w_dvd_next),
        .o_q_bit    (w_q_bit)
    );

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_dvd         <= '0;
            r_dsr         <= '0;
            r_dvd_orig    <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_div_zero    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start__i) begin
                        r_dvd      <= w_dvd_abs;
                        r_dsr      <= w_dsr_abs;
                        r_dvd_orig <= dividend__i;
                        r_q_neg    <= w_dvd_neg ^ w_dsr_neg;
                        r_r_neg    <= w_dvd_neg;
                        r_div_zero <= w_dsr_zero;
                        r_rem      <= '0;
                        r_cnt      <= CNT_W'(WIDTH - 1);
                        r_busy     <= 1'b1;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
                        r_state    <= w_dsr_zero ? FIX : CALC;
`else
                        r_state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    // A zero divisor reports all-ones / original dividend for
                    // both DIV and DIVU, independent of the sign fix-up.
                    if (r_div_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dvd_orig;
                    end else begin
                        r_quotient  <= r_q_neg ? -r_dvd : r_dvd;
                        r_remainder <= r_r_neg ? -r_rem : r_rem;
                    end
                    r_div_by_zero <= r_div_zero;
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy__o      = r_busy;
    assign done__o      = r_done;
    assign quotient__o  = r_quotient;
    assign remainder__o = r_remainder;
    assign divByZero__o = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH = 32).
// Expected results are pushed to a scoreboard queue when an operation is
// started and popped when done__o is seen. Honours SEQ_DIVIDER_ZERO_FAST_EN
// for the zero-divisor latency.
module tb_seq_divider;

    localparam int W        = 32;
    localparam int LAT_FULL = W + 1;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = W + 1;
`endif
    localparam int TIMEOUT  = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sgn;
    logic [W-1:0]  dvd;
    logic [W-1:0]  dsr;
    logic          busy;
    logic          done;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic          dz;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    seq_divider #(.WIDTH(W)) dut (
        .clock__i     (clk),
        .reset__i     (rst),
        .start__i     (start),
        .signed__i    (sgn),
        .dividend__i  (dvd),
        .divisor__i   (dsr),
        .busy__o      (busy),
        .done__o      (done),
        .quotient__o  (quo),
        .remainder__o (rem),
        .divByZero__o (dz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of DIV / DIVU including the two special cases
    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        e.lat = (b == '0) ? LAT_ZERO : LAT_FULL;
        e.dz  = 1'b0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = a;
                e.r = '0;
            end else begin
                sa  = a;
                sb  = b;
                e.q = sa / sb;
                e.r = sa % sb;
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Wait for done__o, optionally pulsing start at cycles 5 and 20, then
    // pop the scoreboard and compare everything visible in the done cycle.
    task automatic wait_done(input string name, input bit glitch);
        int   lat  = 0;
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (glitch && (lat == 5 || lat == 20)) begin
                start = 1'b1;
                dvd   = 32'h0000_DEAD;
                dsr   = 32'h0000_0001;
            end
            tick();
            start = 1'b0;
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (lat == 5) check({name, "_busy_mid"}, 32'(busy), 32'd1);
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            if (sb_q.size() == 0) begin
                check({name, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check({name, "_q"}, quo, e.q);
                check({name, "_r"}, rem, e.r);
                check({name, "_dz"}, 32'(dz), 32'(e.dz));
                check({name, "_lat"}, 32'(lat), 32'(e.lat));
                check({name, "_busy_done"}, 32'(busy), 32'd0);
                last_q = e.q;
                last_r = e.r;
            end
            $display("%s: q=%h r=%h dz=%b latency=%0d", name, quo, rem, dz, lat);
        end
    endtask

    // Start an operation from the current (idle) cycle and push its expectation
    task automatic run_op(input string name, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e, input bit glitch);
        sgn   = s;
        dvd   = a;
        dsr   = b;
        start = 1'b1;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
        check({name, "_busy_E0"}, 32'(busy), 32'd1);
        check({name, "_done_E0"}, 32'(done), 32'd0);
        check({name, "_q_held"}, quo, last_q);
        check({name, "_r_held"}, rem, last_r);
        wait_done(name, glitch);
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic d, input int lat);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dz  = d;
        e.lat = lat;
        return e;
    endfunction

    initial begin
        int           done_cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        dvd   = '0;
        dsr   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        check("rst_q", quo, 32'd0);
        check("rst_r", rem, 32'd0);
        tick();

        // Directed cases with hand-derived results
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, LAT_FULL), 1'b0);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
               mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_FULL), 1'b0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
               mk(32'hFFFF_FFFD, 32'd1, 1'b0, LAT_FULL), 1'b0);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               mk(32'h8000_0000, 32'd0, 1'b0, LAT_FULL), 1'b0);
        run_op("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
               mk(32'd0, 32'h8000_0000, 1'b0, LAT_FULL), 1'b0);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1, LAT_ZERO), 1'b0);
        run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0,
               mk(32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, LAT_ZERO), 1'b0);

        // Start pulses while busy are ignored; next op starts in the done cycle
        run_op("divu_ign", 1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, LAT_FULL), 1'b1);
        check("b2b_done_cycle", 32'(done), 32'd1);
        run_op("b2b_div", 1'b1, 32'hFFFF_FF9C, 32'd7,
               mk(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT_FULL), 1'b0);

        // Random operands checked against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb), 1'b0);
        end

        // Reset in the middle of an operation
        sgn   = 1'b0;
        dvd   = 32'd1000;
        dsr   = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q", quo, 32'd0);
        check("midrst_r", rem, 32'd0);
        check("midrst_dz", 32'(dz), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        $display("midrst: busy=%b done=%b q=%h r=%h after reset", busy, done, quo, rem);
        last_q = '0;
        last_r = '0;
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, mk(32'd3, 32'd0, 1'b0, LAT_FULL), 1'b0);

        // Results hold and done drops after the done cycle
        tick();
        check("hold_done_low", 32'(done), 32'd0);
        check("hold_q", quo, 32'd3);
        check("hold_r", rem, 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
